// File: rtl/fp_compare_pipe.sv
// Two-stage valid/ready comparator for FloPoCo operands {exc, sign, exp, frac}.
// Define FPCMP_MINMAX_EN to add registered min_out/max_out ports.
module fp_compare_pipe #(
    parameter int WE = 7,
    parameter int WF = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          op,
    input  logic [WE+WF+2:0]    inA,
    input  logic [WE+WF+2:0]    inB,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                result,
    output logic                unordered
`ifdef FPCMP_MINMAX_EN
    ,
    output logic [WE+WF+2:0]    min_out,
    output logic [WE+WF+2:0]    max_out
`endif
);

    localparam int W = WE + WF + 3;
    localparam int K = WE + WF + 1;

    typedef struct packed {
        logic         nan;
        logic         sign;
        logic [K-1:0] key;
    } cls_t;

    // Zero and infinity drop their exp/frac so encodings with junk bits still compare equal.
    function automatic cls_t classify(input logic [W-1:0] x);
        cls_t c;
        logic is_zero;
        logic is_inf;
        is_zero = (x[W-1:W-2] == 2'b00);
        is_inf  = (x[W-1:W-2] == 2'b10);
        c.nan   = (x[W-1:W-2] == 2'b11);
        c.sign  = is_zero ? 1'b0 : x[W-3];
        c.key   = (is_zero || is_inf) ? {is_inf, {(K-1){1'b0}}} : {1'b0, x[K-2:0]};
        return c;
    endfunction

    logic       v1;
    logic       v2;
    logic       adv2;
    cls_t       ca1;
    cls_t       cb1;
    logic [2:0] op1;

    assign adv2      = !v2 || out_ready;
    assign in_ready  = !v1 || adv2;
    assign out_valid = v2;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            ca1 <= '0;
            cb1 <= '0;
            op1 <= '0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                ca1 <= classify(inA);
                cb1 <= classify(inB);
                op1 <= op;
            end
        end
    end

`ifdef FPCMP_MINMAX_EN
    logic [W-1:0] a1;
    logic [W-1:0] b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            a1 <= '0;
            b1 <= '0;
        end else if (in_ready && in_valid) begin
            a1 <= inA;
            b1 <= inB;
        end
    end
`endif

    logic lt;
    logic eq;
    logic un;
    logic res_n;

    always_comb begin
        lt    = 1'b0;
        eq    = (ca1.sign == cb1.sign) && (ca1.key == cb1.key);
        un    = ca1.nan || cb1.nan;
        res_n = 1'b0;
        if (ca1.sign != cb1.sign) begin
            lt = ca1.sign;
        end else if (!ca1.sign) begin
            lt = ca1.key < cb1.key;
        end else begin
            lt = ca1.key > cb1.key;
        end
        case (op1)
            3'b000:  res_n = !un && eq;
            3'b001:  res_n = !un && lt;
            3'b010:  res_n = !un && (lt || eq);
            3'b011:  res_n = !un && !lt && !eq;
            3'b100:  res_n = !un && !lt;
            3'b101:  res_n = un || !eq;
            3'b110:  res_n = un;
            default: res_n = 1'b0;
        endcase
    end

`ifdef FPCMP_MINMAX_EN
    logic [W-1:0] min_n;
    logic [W-1:0] max_n;

    // A single NaN is ignored; two NaNs collapse to the canonical NaN.
    always_comb begin
        min_n = b1;
        max_n = a1;
        if (ca1.nan && cb1.nan) begin
            min_n = {2'b11, {(W-2){1'b0}}};
            max_n = {2'b11, {(W-2){1'b0}}};
        end else if (ca1.nan) begin
            min_n = b1;
            max_n = b1;
        end else if (cb1.nan) begin
            min_n = a1;
            max_n = a1;
        end else if (lt || eq) begin
            min_n = a1;
            max_n = b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v2        <= 1'b0;
            result    <= 1'b0;
            unordered <= 1'b0;
`ifdef FPCMP_MINMAX_EN
            min_out   <= '0;
            max_out   <= '0;
`endif
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                result    <= res_n;
                unordered <= un;
`ifdef FPCMP_MINMAX_EN
                min_out   <= min_n;
                max_out   <= max_n;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench for fp_compare_pipe: directed spec cases plus random traffic
// checked against a real-valued reference model. Honours FPCMP_MINMAX_EN.
module tb_fp_compare_pipe;

    localparam int WE = 7;
    localparam int WF = 11;
    localparam int W  = WE + WF + 3;

    localparam logic [W-1:0] P1   = 21'h09F800;
    localparam logic [W-1:0] P2   = 21'h0A0000;
    localparam logic [W-1:0] M1   = 21'h0DF800;
    localparam logic [W-1:0] PZ   = 21'h000000;
    localparam logic [W-1:0] MZ   = 21'h040000;
    localparam logic [W-1:0] PINF = 21'h100000;
    localparam logic [W-1:0] QNAN = 21'h180000;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         out_valid;
    logic         out_ready;
    logic         result;
    logic         unordered;
`ifdef FPCMP_MINMAX_EN
    logic [W-1:0] min_out;
    logic [W-1:0] max_out;
`endif

    fp_compare_pipe #(.WE(WE), .WF(WF)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .inA       (inA),
        .inB       (inB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .unordered (unordered)
`ifdef FPCMP_MINMAX_EN
        ,
        .min_out   (min_out),
        .max_out   (max_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct packed {
        logic         res;
        logic         un;
        logic [W-1:0] mn;
        logic [W-1:0] mx;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   npop   = 0;
    bit   accepted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Real value of an operand; infinity maps to a value far beyond any normal.
    function automatic real toReal(input logic [W-1:0] x);
        real v;
        if (x[W-1:W-2] == 2'b00) return 0.0;
        if (x[W-1:W-2] == 2'b10) v = 1.0e300;
        else begin
            v = 1.0 + real'(x[WF-1:0]) / 2048.0;
            for (int i = 0; i < int'(x[WE+WF-1:WF]); i++) v = v * 2.0;
            for (int i = 0; i < 63; i++) v = v / 2.0;
        end
        return x[W-3] ? -v : v;
    endfunction

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic na;
        logic nb;
        real  va;
        real  vb;
        na   = (a[W-1:W-2] == 2'b11);
        nb   = (b[W-1:W-2] == 2'b11);
        e.un = na || nb;
        if (e.un) begin
            e.res = (o == 3'd5) || (o == 3'd6);
            if (na && nb) begin e.mn = QNAN; e.mx = QNAN; end
            else if (na) begin e.mn = b; e.mx = b; end
            else begin e.mn = a; e.mx = a; end
        end else begin
            va = toReal(a);
            vb = toReal(b);
            case (o)
                3'd0:    e.res = (va == vb);
                3'd1:    e.res = (va < vb);
                3'd2:    e.res = (va <= vb);
                3'd3:    e.res = (va > vb);
                3'd4:    e.res = (va >= vb);
                3'd5:    e.res = (va != vb);
                default: e.res = 1'b0;
            endcase
            if (va <= vb) begin e.mn = a; e.mx = b; end
            else begin e.mn = b; e.mx = a; end
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v;
        op       = o;
        inA      = a;
        inB      = b;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (q.size() == 0) begin
            chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
            e = q.pop_front();
            npop++;
            chk("result", 32'(result), 32'(e.res));
            chk("unordered", 32'(unordered), 32'(e.un));
`ifdef FPCMP_MINMAX_EN
            chk("min_out", 32'(min_out), 32'(e.mn));
            chk("max_out", 32'(max_out), 32'(e.mx));
`endif
        end
    endtask

    // Sample handshakes on the falling edge, let the rising edge commit them.
    task automatic tick();
        @(negedge clk);
        accepted = 1'b0;
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
            if (out_valid && out_ready) checkOutput();
            if (in_valid && in_ready) begin
                q.push_back(model(op, inA, inB));
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runOne(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic er, input logic eu);
        applyStimulus(1'b1, o, a, b);
        tick();
        applyStimulus(1'b0, 3'd0, '0, '0);
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_un"}, 32'(unordered), 32'(eu));
    endtask

`ifdef FPCMP_MINMAX_EN
    task automatic runMinMax(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] emin, input logic [W-1:0] emax);
        runOne(tag, 3'd2, a, b, model(3'd2, a, b).res, model(3'd2, a, b).un);
        chk({tag, "_min"}, 32'(min_out), 32'(emin));
        chk({tag, "_max"}, 32'(max_out), 32'(emax));
    endtask
`endif

    function automatic logic [W-1:0] genOperand();
        logic [W-1:0] x;
        case ($urandom_range(0, 7))
            0:       x = {2'b00, 19'($urandom)};
            1:       x = {2'b10, 19'($urandom)};
            2:       x = {2'b11, 19'($urandom)};
            default: x = {2'b01, 1'($urandom), 7'($urandom_range(61, 65)), 11'($urandom_range(0, 3) << 9)};
        endcase
        return x;
    endfunction

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sent;
        int           pop0;
        logic [2:0]   bpOp[4];
        logic [W-1:0] bpA[4];
        logic [W-1:0] bpB[4];

        rst = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 3'd0, '0, '0);
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_unordered", 32'(unordered), 32'd0);
        tick();

        runOne("lt_p1_p2", 3'd1, P1, P2, 1'b1, 1'b0);
        runOne("gt_p1_p2", 3'd3, P1, P2, 1'b0, 1'b0);
        runOne("eq_pz_mz", 3'd0, PZ, MZ, 1'b1, 1'b0);
        runOne("lt_m1_pz", 3'd1, M1, PZ, 1'b1, 1'b0);
        runOne("ge_inf_p2", 3'd4, PINF, P2, 1'b1, 1'b0);
        runOne("eq_nan", 3'd0, QNAN, P1, 1'b0, 1'b1);
        runOne("lt_nan", 3'd1, QNAN, P1, 1'b0, 1'b1);
        runOne("ge_nan", 3'd4, QNAN, P1, 1'b0, 1'b1);
        runOne("ne_nan", 3'd5, QNAN, P1, 1'b1, 1'b1);
        runOne("un_nan", 3'd6, QNAN, P1, 1'b1, 1'b1);
        runOne("op7_nan", 3'd7, QNAN, P1, 1'b0, 1'b1);
        runOne("op7_eq", 3'd7, P1, P1, 1'b0, 1'b0);
`ifdef FPCMP_MINMAX_EN
        runMinMax("mm_m1_nan", M1, QNAN, M1, M1);
        runMinMax("mm_nan_nan", QNAN, QNAN, QNAN, QNAN);
        runMinMax("mm_p2_p1", P2, P1, P1, P2);
`endif
        tick();

        // Backpressure: two pairs fill the pipe, then the held output must stay put.
        bpOp = '{3'd1, 3'd3, 3'd0, 3'd6};
        bpA  = '{P1, P1, PZ, QNAN};
        bpB  = '{P2, P2, MZ, P1};
        pop0 = npop;
        out_ready = 1'b0;
        sent = 0;
        applyStimulus(1'b1, bpOp[0], bpA[0], bpB[0]);
        for (int t = 0; t < 10 && sent < 2; t++) begin
            tick();
            if (accepted) begin
                sent++;
                applyStimulus(1'b1, bpOp[sent], bpA[sent], bpB[sent]);
            end
        end
        chk("bp_sent", 32'(sent), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_result", 32'(result), 32'(q[0].res));
            chk("bp_hold_unordered", 32'(unordered), 32'(q[0].un));
        end
        out_ready = 1'b1;
        for (int t = 0; t < 10 && sent < 4; t++) begin
            tick();
            if (accepted) begin
                sent++;
                if (sent < 4) applyStimulus(1'b1, bpOp[sent], bpA[sent], bpB[sent]);
                else applyStimulus(1'b0, 3'd0, '0, '0);
            end
        end
        for (int t = 0; t < 10 && q.size() > 0; t++) tick();
        chk("bp_drained", 32'(q.size()), 32'd0);
        chk("bp_count", 32'(npop - pop0), 32'd4);

        // Reset while two results are in flight.
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'd5, QNAN, P1);
        tick();
        tick();
        applyStimulus(1'b0, 3'd0, '0, '0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_result", 32'(result), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_unordered", 32'(unordered), 32'd0);
`ifdef FPCMP_MINMAX_EN
        chk("rst_min", 32'(min_out), 32'd0);
        chk("rst_max", 32'(max_out), 32'd0);
`endif
        q.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("post_rst_no_output", 32'(out_valid), 32'd0);
        end

        // Random traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            ra = genOperand();
            case ($urandom_range(0, 7))
                0, 1:    rb = ra;
                2:       rb = ra ^ 21'h040000;
                default: rb = genOperand();
            endcase
            applyStimulus(1'($urandom_range(0, 9) < 7), 3'($urandom), ra, rb);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        applyStimulus(1'b0, 3'd0, '0, '0);
        out_ready = 1'b1;
        for (int t = 0; t < 10 && q.size() > 0; t++) tick();
        chk("rand_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
